// File: rtl/expr_eval.sv
// Evaluates single-digit "+"/"*" expressions terminated by '=' with normal precedence.
// Optional: define EXPR_EVAL_OVF_EN to flag arithmetic overflow as an error (value saturates to all ones).
module expr_eval #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic         done,
    output logic [W-1:0] value,
    output logic         err,
    output logic         busy
);

`ifdef EXPR_EVAL_OVF_EN
    localparam int AW = 2 * W;
`else
    localparam int AW = W;
`endif

    typedef enum logic [1:0] {S_DIG, S_OP, S_ERR} state_t;

    state_t         state_reg;
    logic [W-1:0]   sum_reg;
    logic [W-1:0]   term_reg;
    logic           pend_mul_reg;

    logic           is_digit;
    logic           is_plus;
    logic           is_star;
    logic           is_eq;
    logic [AW-1:0]  digit_ext;
    logic [AW-1:0]  prod_w;
    logic [AW-1:0]  sum_w;
    logic           final_ovf;

`ifdef EXPR_EVAL_OVF_EN
    logic           ovf_reg;
    logic           prod_ovf;
    logic           sum_ovf;
`endif

    always_comb begin
        is_digit  = (in >= 8'h30) && (in <= 8'h39);
        is_plus   = (in == 8'h2B);
        is_star   = (in == 8'h2A);
        is_eq     = (in == 8'h3D);
        digit_ext = AW'(in[3:0]);
        prod_w    = AW'(term_reg) * digit_ext;
        sum_w     = AW'(sum_reg) + AW'(term_reg);
`ifdef EXPR_EVAL_OVF_EN
        prod_ovf  = |prod_w[AW-1:W];
        sum_ovf   = |sum_w[AW-1:W];
        final_ovf = ovf_reg | sum_ovf;
`else
        final_ovf = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg    <= S_DIG;
            sum_reg      <= '0;
            term_reg     <= '0;
            pend_mul_reg <= 1'b0;
            value        <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
            ovf_reg      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (in_valid) begin
                if (is_eq) begin
                    // Terminator: report and clear, whatever state we were in.
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    sum_reg      <= '0;
                    term_reg     <= '0;
                    pend_mul_reg <= 1'b0;
                    state_reg    <= S_DIG;
`ifdef EXPR_EVAL_OVF_EN
                    ovf_reg      <= 1'b0;
`endif
                    if (state_reg == S_OP) begin
                        if (final_ovf) begin
                            value <= '1;
                            err   <= 1'b1;
                        end else begin
                            value <= sum_w[W-1:0];
                            err   <= 1'b0;
                        end
                    end else begin
                        value <= '0;
                        err   <= 1'b1;
                    end
                end else begin
                    busy <= 1'b1;
                    case (state_reg)
                        S_DIG: begin
                            if (is_digit) begin
                                term_reg  <= pend_mul_reg ? prod_w[W-1:0] : digit_ext[W-1:0];
`ifdef EXPR_EVAL_OVF_EN
                                if (pend_mul_reg && prod_ovf)
                                    ovf_reg <= 1'b1;
`endif
                                state_reg <= S_OP;
                            end else begin
                                state_reg <= S_ERR;
                            end
                        end
                        S_OP: begin
                            if (is_plus) begin
                                sum_reg      <= sum_w[W-1:0];
                                pend_mul_reg <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
                                if (sum_ovf)
                                    ovf_reg <= 1'b1;
`endif
                                state_reg    <= S_DIG;
                            end else if (is_star) begin
                                pend_mul_reg <= 1'b1;
                                state_reg    <= S_DIG;
                            end else begin
                                state_reg <= S_ERR;
                            end
                        end
                        default: begin
                            // Draining an erroneous expression until '='.
                            state_reg <= S_ERR;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// Directed-vector bench for expr_eval: a W=16 instance for the main checks and a W=8 instance for wrap/overflow.
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in;

    logic        done16;
    logic [15:0] value16;
    logic        err16;
    logic        busy16;

    logic        done8;
    logic [7:0]  value8;
    logic        err8;
    logic        busy8;

    int tests_run;
    int tests_failed;
    int done_cnt;

    expr_eval #(.W(16)) u16 (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .done     (done16),
        .value    (value16),
        .err      (err16),
        .busy     (busy16)
    );

    expr_eval #(.W(8)) u8 (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .done     (done8),
        .value    (value8),
        .err      (err8),
        .busy     (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!clr && done16)
            done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Presents one character starting at a negedge; returns at the next negedge, after it was consumed.
    task automatic put(input logic [7:0] c);
        in       = c;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic expr(input string s, input int ev, input int ee);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            put(c);
            if (c == 8'h3D) begin
                check_eq({s, " done"},  32'(done16),  32'd1);
                check_eq({s, " value"}, 32'(value16), 32'(ev));
                check_eq({s, " err"},   32'(err16),   32'(ee));
                check_eq({s, " busy"},  32'(busy16),  32'd0);
            end else begin
                check_eq({s, " no early done"}, 32'(done16), 32'd0);
                check_eq({s, " busy mid"},      32'(busy16), 32'd1);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        clr          = 1'b1;
        in_valid     = 1'b0;
        in           = 8'h00;

        #1;
        check_eq("reset value", 32'(value16), 32'd0);
        check_eq("reset err",   32'(err16),   32'd0);
        check_eq("reset done",  32'(done16),  32'd0);
        check_eq("reset busy",  32'(busy16),  32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        // Precedence, then a second expression with no idle cycle between.
        expr("3+4*5=", 23, 0);
        expr("2*3*4+1=", 25, 0);
        @(negedge clk);
        check_eq("done one cycle only", 32'(done16), 32'd0);
        check_eq("two dones so far", 32'(done_cnt), 32'd2);

        // Single digit with an input gap.
        put(8'h37);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("gap busy", 32'(busy16), 32'd1);
            check_eq("gap done", 32'(done16), 32'd0);
        end
        expr("=", 7, 0);

        // Syntax errors and recovery.
        expr("3++4=", 0, 1);
        expr("=", 0, 1);
        expr("5*=", 0, 1);
        expr("5a9=", 0, 1);
        expr("9=", 9, 0);

        // Asynchronous reset mid-expression.
        put(8'h35);
        put(8'h2A);
        in_valid = 1'b0;
        #2 clr = 1'b1;
        #1;
        check_eq("clr busy",  32'(busy16),  32'd0);
        check_eq("clr value", 32'(value16), 32'd0);
        check_eq("clr done",  32'(done16),  32'd0);
        #1 clr = 1'b0;
        @(negedge clk);
        check_eq("no done from reset", 32'(done_cnt), 32'd8);
        expr("6=", 6, 0);

        // W=8 wrap / overflow.
        expr("9*9*9=", 729, 0);
`ifdef EXPR_EVAL_OVF_EN
        check_eq("w8 9*9*9 value", 32'(value8), 32'd255);
        check_eq("w8 9*9*9 err",   32'(err8),   32'd1);
`else
        check_eq("w8 9*9*9 value", 32'(value8), 32'd217);
        check_eq("w8 9*9*9 err",   32'(err8),   32'd0);
`endif
        check_eq("w8 done", 32'(done8), 32'd1);
        expr("2+2=", 4, 0);
        check_eq("w8 2+2 value", 32'(value8), 32'd4);
        check_eq("w8 2+2 err",   32'(err8),   32'd0);

        // Hold: result stays put while idle and while a new expression is entered.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("hold idle value", 32'(value16), 32'd4);
            check_eq("hold idle err",   32'(err16),   32'd0);
        end
        put(8'h31);
        put(8'h2B);
        put(8'h32);
        in_valid = 1'b0;
        check_eq("hold partial value", 32'(value16), 32'd4);
        check_eq("hold partial err",   32'(err16),   32'd0);
        @(negedge clk);
        expr("=", 3, 0);

        @(negedge clk);
        check_eq("total dones", 32'(done_cnt), 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
